// File: rtl/fe_pkg.sv
// Shared front-end types: instruction/PC width, decoded bundle width and queue entry layout.
package fe_pkg;

  localparam int WORD_SIZE                 = 16;
  localparam int DECODED_INSTRUCTION_WIDTH = 64;

  typedef struct packed {
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] pc;
  } fe_queue_entry_s;

endpackage

// File: rtl/fe_decode_ctrl_if.sv
// Fetch, decoder, back-end and flush signals of the front-end sequencer.
// master = surrounding pipeline, slave = fe_decode_ctrl.
interface fe_decode_ctrl_if
  import fe_pkg::*;
#(
  parameter int WORD_SIZE_P               = WORD_SIZE,
  parameter int DECODED_INSTRUCTION_WIDTH = fe_pkg::DECODED_INSTRUCTION_WIDTH,
  parameter int DEPTH_P                   = 4
);

  logic                                 fetch_v_i;
  logic [WORD_SIZE_P-1:0]               fetch_inst_i;
  logic [WORD_SIZE_P-1:0]               fetch_pc_i;
  logic                                 fetch_ready_o;
  logic [WORD_SIZE_P-1:0]               dec_inst_o;
  logic [DECODED_INSTRUCTION_WIDTH-1:0] dec_i;
  logic                                 be_v_o;
  logic [DECODED_INSTRUCTION_WIDTH-1:0] be_decoded_o;
  logic [WORD_SIZE_P-1:0]               be_pc_o;
  logic                                 be_ready_i;
  logic                                 flush_i;
  logic [$clog2(DEPTH_P):0]             count_o;

  modport master (
    output fetch_v_i, fetch_inst_i, fetch_pc_i, dec_i, be_ready_i, flush_i,
    input  fetch_ready_o, dec_inst_o, be_v_o, be_decoded_o, be_pc_o, count_o
  );

  modport slave (
    input  fetch_v_i, fetch_inst_i, fetch_pc_i, dec_i, be_ready_i, flush_i,
    output fetch_ready_o, dec_inst_o, be_v_o, be_decoded_o, be_pc_o, count_o
  );

endinterface

// File: rtl/fe_inst_fifo.sv
// Circular instruction queue of {inst, pc}; head is combinational from the read pointer.
// Caller guarantees no enq when full and no deq when empty; flush clears pointers and count.
module fe_inst_fifo
  import fe_pkg::*;
#(
  parameter int DEPTH_P = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq,
  input  logic                     deq,
  input  logic                     flush,
  input  fe_queue_entry_s          wr_entry,
  output fe_queue_entry_s          head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH_P):0] count
);

  localparam int AW = $clog2(DEPTH_P);
  localparam int CW = AW + 1;

  fe_queue_entry_s mem [DEPTH_P];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH_P));
  assign empty = (count == '0);

  // Pointers are exactly log2(depth) wide, so increment wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH_P; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (deq && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fe_decode_ctrl.sv
// Front-end sequencer: queues fetched words, registers decoder output for the back end.
// Fetch-to-be_v latency 2 cycles; be_* held stable while be_ready_i is low; flush drops everything.
module fe_decode_ctrl
  import fe_pkg::*;
#(
  parameter int WORD_SIZE_P               = WORD_SIZE,
  parameter int DECODED_INSTRUCTION_WIDTH = fe_pkg::DECODED_INSTRUCTION_WIDTH,
  parameter int DEPTH_P                   = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  fe_decode_ctrl_if.slave   bus
);

  logic                                 enq;
  logic                                 load;
  logic                                 full;
  logic                                 empty;
  fe_queue_entry_s                      wr_entry;
  fe_queue_entry_s                      head;
  logic [$clog2(DEPTH_P):0]             count;
  logic                                 be_v;
  logic [DECODED_INSTRUCTION_WIDTH-1:0] be_decoded;
  logic [WORD_SIZE_P-1:0]               be_pc;

  // No full-queue bypass: a dequeue in the same cycle does not open a slot.
  assign enq      = bus.fetch_v_i & ~full & ~bus.flush_i;
  assign load     = ~empty & (~be_v | bus.be_ready_i) & ~bus.flush_i;
  assign wr_entry = '{inst: bus.fetch_inst_i, pc: bus.fetch_pc_i};

  fe_inst_fifo #(
    .DEPTH_P (DEPTH_P)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .enq      (enq),
    .deq      (load),
    .flush    (bus.flush_i),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      be_v       <= 1'b0;
      be_decoded <= '0;
      be_pc      <= '0;
    end else if (bus.flush_i) begin
      be_v <= 1'b0;
    end else if (load) begin
      be_v       <= 1'b1;
      be_decoded <= bus.dec_i;
      be_pc      <= head.pc;
    end else if (be_v && bus.be_ready_i) begin
      be_v <= 1'b0;
    end
  end

  assign bus.fetch_ready_o = ~full;
  assign bus.dec_inst_o    = head.inst;
  assign bus.be_v_o        = be_v;
  assign bus.be_decoded_o  = be_decoded;
  assign bus.be_pc_o       = be_pc;
  assign bus.count_o       = count;

endmodule

// File: tb/tb_fe_decode_ctrl.sv
// Randomized bench for fe_decode_ctrl: queue-based reference model plus directed literal checks.
module tb_fe_decode_ctrl;
  import fe_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fe_decode_ctrl_if #(.WORD_SIZE_P(16), .DECODED_INSTRUCTION_WIDTH(64), .DEPTH_P(DEPTH)) bus ();

  fe_decode_ctrl #(.WORD_SIZE_P(16), .DECODED_INSTRUCTION_WIDTH(64), .DEPTH_P(DEPTH)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // Stand-in combinational decoder sitting at the parent level.
  function automatic logic [63:0] decode(input logic [15:0] x);
    return {x, ~x, x ^ 16'h5A5A, x + 16'h1111};
  endfunction

  assign bus.dec_i = decode(bus.dec_inst_o);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of pending words plus one output slot.
  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          mv;
  logic [63:0] mdec;
  logic [15:0] mpc;
  bit          checking = 0;

  initial begin
    mv = 0; mdec = '0; mpc = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); mv = 0; mdec = '0; mpc = '0;
      end else begin
        bit   do_enq, do_load;
        ent_t e;
        do_enq  = bus.fetch_v_i && (mq.size() < DEPTH) && !bus.flush_i;
        do_load = (mq.size() > 0) && (!mv || bus.be_ready_i) && !bus.flush_i;
        if (bus.flush_i) begin
          mq.delete();
          mv = 0;
        end else begin
          if (do_load) begin
            mv   = 1;
            mdec = decode(mq[0].inst);
            mpc  = mq[0].pc;
            void'(mq.pop_front());
          end else if (mv && bus.be_ready_i) begin
            mv = 0;
          end
          if (do_enq) begin
            e.inst = bus.fetch_inst_i;
            e.pc   = bus.fetch_pc_i;
            mq.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("m_be_v", 64'(bus.be_v_o), 64'(mv));
        chk("m_count", 64'(bus.count_o), 64'(mq.size()));
        chk("m_fetch_ready", 64'(bus.fetch_ready_o), 64'(mq.size() < DEPTH));
        if (mv) begin
          chk("m_be_pc", 64'(bus.be_pc_o), 64'(mpc));
          chk("m_be_decoded", bus.be_decoded_o, mdec);
        end
        if (mq.size() > 0) begin
          chk("m_dec_inst", 64'(bus.dec_inst_o), 64'(mq[0].inst));
        end
      end
    end
  end

  // Back-end acceptance log: recorded when be_v and be_ready are both set for the coming edge.
  logic [15:0] acc_log[$];
  task automatic commit();
    if (bus.be_v_o && bus.be_ready_i) acc_log.push_back(bus.be_pc_o);
  endtask

  // Offer word k of a block; advance only when the queue will take it.
  task automatic offer(input logic [15:0] base_inst, input logic [15:0] base_pc,
                       input int n, inout int idx);
    if (idx < n) begin
      bus.fetch_v_i    = 1'b1;
      bus.fetch_inst_i = base_inst + 16'(idx);
      bus.fetch_pc_i   = base_pc + 16'(idx);
      if (bus.fetch_ready_o && !bus.flush_i) idx++;
    end else begin
      bus.fetch_v_i = 1'b0;
    end
  endtask

  initial begin
    int idx, vcnt, maxc, guard;
    bus.fetch_v_i = 0; bus.fetch_inst_i = '0; bus.fetch_pc_i = '0;
    bus.be_ready_i = 0; bus.flush_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_be_v", 64'(bus.be_v_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_ready", 64'(bus.fetch_ready_o), 64'd1);
    chk("rst_be_pc", 64'(bus.be_pc_o), 64'd0);
    chk("rst_be_decoded", bus.be_decoded_o, 64'd0);
    rst_n = 1'b1;
    checking = 1;

    // Single instruction: be_v two edges after acceptance.
    @(negedge clk);
    bus.fetch_v_i = 1; bus.fetch_inst_i = 16'h1234; bus.fetch_pc_i = 16'h0100; bus.be_ready_i = 1;
    @(negedge clk);
    bus.fetch_v_i = 0;
    chk("t1_count", 64'(bus.count_o), 64'd1);
    chk("t1_dec_inst", 64'(bus.dec_inst_o), 64'h1234);
    chk("t1_be_v_early", 64'(bus.be_v_o), 64'd0);
    @(negedge clk);
    chk("t1_be_v", 64'(bus.be_v_o), 64'd1);
    chk("t1_be_pc", 64'(bus.be_pc_o), 64'h0100);
    chk("t1_be_decoded", bus.be_decoded_o, 64'h1234_EDCB_486E_2345);
    @(negedge clk);
    chk("t1_be_v_drop", 64'(bus.be_v_o), 64'd0);

    // Back-to-back stream of 8 with the back end always ready.
    acc_log.delete(); vcnt = 0; maxc = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.be_v_o) vcnt++;
      if (int'(bus.count_o) > maxc) maxc = int'(bus.count_o);
      bus.fetch_v_i    = (i < 8);
      bus.fetch_inst_i = 16'hA000 + 16'(i);
      bus.fetch_pc_i   = 16'h0200 + 16'(i);
      commit();
    end
    chk("t2_valid_cycles", 64'(vcnt), 64'd8);
    chk("t2_max_count", 64'(maxc), 64'd1);
    chk("t2_log_size", 64'(acc_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("t2_order", 64'(acc_log[i]), 64'(16'h0200 + 16'(i)));

    // Stall the back end until the queue fills, then release and drain.
    acc_log.delete(); idx = 0; bus.be_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      offer(16'hB000, 16'h0300, 6, idx);
    end
    @(negedge clk);
    chk("t3_count_full", 64'(bus.count_o), 64'd4);
    chk("t3_ready_low", 64'(bus.fetch_ready_o), 64'd0);
    chk("t3_held_pc", 64'(bus.be_pc_o), 64'h0300);
    bus.be_ready_i = 1;
    offer(16'hB000, 16'h0300, 6, idx);
    commit();
    @(negedge clk);
    chk("t4_count_dec", 64'(bus.count_o), 64'd3);
    guard = 0;
    while ((idx < 6 || bus.count_o != 0 || bus.be_v_o) && guard < 50) begin
      offer(16'hB000, 16'h0300, 6, idx);
      commit();
      @(negedge clk);
      guard++;
    end
    bus.fetch_v_i = 0;
    chk("t3_drain_timeout", 64'(guard < 50), 64'd1);
    chk("t3_log_size", 64'(acc_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("t3_order", 64'(acc_log[i]), 64'(16'h0300 + 16'(i)));

    // Flush with three queued, one registered, and a fetch offered the same cycle.
    idx = 0; bus.be_ready_i = 0; guard = 0;
    while ((bus.count_o != 3 || !bus.be_v_o) && guard < 20) begin
      offer(16'hC000, 16'h0400, 4, idx);
      @(negedge clk);
      guard++;
    end
    chk("t5_setup_count", 64'(bus.count_o), 64'd3);
    chk("t5_setup_be_v", 64'(bus.be_v_o), 64'd1);
    bus.flush_i = 1; bus.fetch_v_i = 1; bus.fetch_inst_i = 16'hBEEF; bus.fetch_pc_i = 16'hBEEF;
    @(negedge clk);
    bus.flush_i = 0; bus.fetch_v_i = 0; bus.be_ready_i = 1;
    chk("t5_count", 64'(bus.count_o), 64'd0);
    chk("t5_be_v", 64'(bus.be_v_o), 64'd0);
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.be_v_o) vcnt++;
    end
    chk("t5_no_ghost", 64'(vcnt), 64'd0);

    // Asynchronous reset between edges with the queue half full.
    idx = 0; bus.be_ready_i = 0; guard = 0;
    while ((bus.count_o != 2 || !bus.be_v_o) && guard < 20) begin
      offer(16'hD000, 16'h0500, 3, idx);
      @(negedge clk);
      guard++;
    end
    bus.fetch_v_i = 0;
    chk("t6_setup_count", 64'(bus.count_o), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_be_v", 64'(bus.be_v_o), 64'd0);
    chk("t6_async_count", 64'(bus.count_o), 64'd0);
    chk("t6_async_ready", 64'(bus.fetch_ready_o), 64'd1);
    chk("t6_async_be_pc", 64'(bus.be_pc_o), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_ready", 64'(bus.fetch_ready_o), 64'd1);
    chk("t6_post_count", 64'(bus.count_o), 64'd0);

    // Random traffic against the model; two back-pressure regimes.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.fetch_v_i    = ($urandom_range(0, 3) != 0);
      bus.fetch_inst_i = 16'($urandom);
      bus.fetch_pc_i   = 16'($urandom);
      bus.be_ready_i   = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.flush_i      = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    bus.fetch_v_i = 0; bus.flush_i = 0; bus.be_ready_i = 1;
    repeat (10) @(negedge clk);
    chk("end_idle_count", 64'(bus.count_o), 64'd0);
    chk("end_idle_be_v", 64'(bus.be_v_o), 64'd0);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
